// File: rtl/srm_controller_if.sv
// srm_controller_if: start handshake and datapath control bundle between requester and controller
interface srm_controller_if;
  logic        s;
  logic [15:0] in;
  logic        w, err, write, loada, loadb, loadc, loads, asel, bsel;
  logic [1:0]  vsel, shift, ALUop;
  logic [2:0]  readnum, writenum;
  logic [15:0] sximm5, sximm8;
  modport master (output s, in, input w, err, write, loada, loadb, loadc, loads, asel, bsel, vsel, readnum, writenum, shift, ALUop, sximm5, sximm8);
  modport slave (input s, in, output w, err, write, loada, loadb, loadc, loads, asel, bsel, vsel, readnum, writenum, shift, ALUop, sximm5, sximm8);
endinterface

// File: rtl/srm_controller.sv
// srm_controller: multi-cycle sequencer driving the Simple RISC Machine datapath controls
module srm_controller (
  input logic clk,
  input logic reset,
  srm_controller_if.slave bus
);
  typedef enum logic [3:0] {WAIT, DECODE, WIMM, GETA, GETB, EXEC, CMPS, WRC, BAD} state_t;
  typedef struct packed {
    logic       w, err, write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0] vsel;
    logic [2:0] readnum, writenum;
  } ctl_t;
  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [4:0]  dec;
  ctl_t        ctl_q, ctl_d;
  always_comb begin
    ir_d = (state_q == WAIT && bus.s) ? bus.in : ir_q;
    dec = ir_q[15:11];
    state_d = WAIT;
    case (state_q)
      WAIT:   state_d = bus.s ? DECODE : WAIT;
      DECODE: state_d = dec == 5'b11010 ? WIMM :
                        (dec == 5'b11000 || dec == 5'b10111) ? GETB :
                        dec[4:2] == 3'b101 ? GETA : BAD;
      GETA:   state_d = GETB;
      GETB:   state_d = dec == 5'b10101 ? CMPS : EXEC;
      EXEC:   state_d = WRC;
      default: state_d = WAIT;
    endcase
    // outputs are computed for the state being entered so they register alongside it
    ctl_d = '0;
    ctl_d.w = state_d == WAIT;
    ctl_d.err = state_d == BAD;
    ctl_d.write = state_d == WIMM || state_d == WRC;
    ctl_d.vsel = state_d == WIMM ? 2'b10 : 2'b00;
    ctl_d.writenum = state_d == WIMM ? ir_d[10:8] : state_d == WRC ? ir_d[7:5] : 3'd0;
    ctl_d.readnum = state_d == GETA ? ir_d[10:8] : state_d == GETB ? ir_d[2:0] : 3'd0;
    ctl_d.loada = state_d == GETA;
    ctl_d.loadb = state_d == GETB;
    ctl_d.loadc = state_d == EXEC;
    ctl_d.loads = state_d == CMPS;
    ctl_d.asel = state_d == EXEC && (ir_d[15:11] == 5'b11000 || ir_d[15:11] == 5'b10111);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT;
      ir_q <= '0;
      ctl_q <= '0;
      ctl_q.w <= 1'b1;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
      ctl_q <= ctl_d;
    end
  end
  assign bus.w = ctl_q.w;
  assign bus.err = ctl_q.err;
  assign bus.write = ctl_q.write;
  assign bus.loada = ctl_q.loada;
  assign bus.loadb = ctl_q.loadb;
  assign bus.loadc = ctl_q.loadc;
  assign bus.loads = ctl_q.loads;
  assign bus.asel = ctl_q.asel;
  assign bus.bsel = ctl_q.bsel;
  assign bus.vsel = ctl_q.vsel;
  assign bus.readnum = ctl_q.readnum;
  assign bus.writenum = ctl_q.writenum;
  assign bus.shift = ir_q[4:3];
  assign bus.ALUop = ir_q[12:11];
  assign bus.sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};
  assign bus.sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
endmodule

// File: doc/srm_controller.md
# srm_controller

Finite-state controller that sits directly upstream of the Simple RISC Machine datapath and drives every datapath control input. It captures a 16-bit instruction on a start handshake, decodes it, and sequences register reads, ALU execution, status update and register write-back over several cycles. It supports MOV immediate, MOV register, ADD, CMP, AND and MVN, and it flags illegal encodings. Completion is signalled with a wait/ready output.

## Interface
No parameters.
- clk  input  1  rising-edge clock shared with datapath
- reset  input  1  synchronous, active-high; one clock; reset has priority over all other inputs
- s  input  1  start request; sampled only in WAIT
- in  input  16  instruction from instruction register; captured on accepted start
- w  output  1  1 = idle/ready (WAIT state)
- err  output  1  1 for exactly one cycle (BAD state) on illegal instruction
- vsel  output  2  write-back source: 00 C, 01 PC, 10 sximm8, 11 mdata
- readnum, writenum  output  3 each  register-file read/write index
- write, loada, loadb, loadc, loads  output  1 each  register-file write / A / B / C / status load enables
- asel, bsel  output  1 each  asel=1 → A operand 0; bsel=1 → sximm5
- shift  output  2  = ir[4:3]
- ALUop  output  2  = ir[12:11]
- sximm5  output  16  sign-extended ir[4:0]
- sximm8  output  16  sign-extended ir[7:0]

## Operation
- Internal 16-bit ir register: loads `in` on the edge where state=WAIT and s=1; otherwise holds. Fields: opcode ir[15:13], op ir[12:11], Rn ir[10:8], Rd ir[7:5], Rm ir[2:0].
- Moore outputs, decoded from state and ir only; no input-to-output combinational paths.
- Default in every state unless listed: write, loada, loadb, loadc, loads, asel, bsel = 0; vsel = 00; readnum = writenum = 0; err = 0; w = 0.
- shift, ALUop, sximm5, sximm8 are always driven from ir.
- States and asserted outputs:
  - WAIT: w=1.
  - DECODE: no assertions.
  - WIMM: write=1, vsel=10, writenum=Rn.
  - GETA: loada=1, readnum=Rn.
  - GETB: loadb=1, readnum=Rm.
  - EXEC: loadc=1, asel=1 for MOV register and MVN, otherwise 0.
  - CMPS: loads=1.
  - WRC: write=1, vsel=00, writenum=Rd.
  - BAD: err=1.
- Transitions:
  - WAIT→DECODE when s=1; otherwise stay.
  - DECODE:
    - 110/10 → WIMM
    - 110/00 and 101/11 → GETB
    - 101/00, 101/01, 101/10 → GETA
    - anything else → BAD
  - WIMM→WAIT.
  - GETA→GETB.
  - GETB: →CMPS if op is CMP (101/01); else →EXEC.
  - EXEC→WRC.
  - WRC→WAIT.
  - CMPS→WAIT.
  - BAD→WAIT.
- CMP never asserts write or loadc. Illegal instructions assert no load or write enable.
- The datapath ALU computes MOV register as 0 + shifted Rm (ALUop 00) and MVN as ~shifted Rm.

## Timing
- Reset: on the reset edge, state←WAIT and ir←0. In the following cycle w=1, err=0, and every enable is 0. A reset mid-instruction aborts it; no enable is asserted after the reset edge.
- Handshake:
  - s is ignored while w=0.
  - w drops in the cycle after s is accepted and rises again in the cycle after the final execution state.
  - If s is held high in WAIT, the next instruction is accepted after exactly one WAIT cycle (back-to-back).
- `in` only needs to be valid at the accepting edge; later changes have no effect.
- Busy cycles (w=0) per instruction:
  - MOV immediate: 2
  - MOV register / MVN: 4
  - ADD / AND: 5
  - CMP: 4
  - illegal: 2
- Each enable is asserted for exactly one cycle per instruction.

## Test plan
- Reset then idle: assert reset for one edge with s=1 → w=1, all enables 0, ir=0. Deassert reset with s=0 → stays in WAIT indefinitely.
- MOV R1,#-16 (in=0xD1F0):
  - pulse s → DECODE, then WIMM with write=1, vsel=10, writenum=1, sximm8=0xFFF0.
  - w=1 on the next cycle. With the datapath attached, R1=0xFFF0.
- ADD R2,R1,R0,LSL#1 (0xA148) after R0=7, R1=3:
  - sequence GETA(readnum=1), GETB(readnum=0), EXEC(loadc, asel=0, shift=01), WRC(writenum=2).
  - 5 busy cycles; R2=17.
- CMP R0,R1 (0xA801) with R0=R1=7 → loads=1 in the 4th busy cycle, write never asserted, Z_out=1, N_out=0.
- MVN R3,R2 (0xB862) with R2=17 → GETB, EXEC with asel=1, WRC writenum=3; R3=0xFFEE; 4 busy cycles.
- Illegal and abort:
  - in=0x0000 → err=1 for one cycle, no enables asserted, w=1 after 2 busy cycles.
  - Separately, assert reset during GETB of an ADD → WAIT next cycle, and loadc/write are never asserted.
